// File: rtl/tff_sched_pkg.sv
// Shared definitions for the toggle-bank scheduler: FSM state encoding and
// default sizing for the requester count and bank width.
package tff_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/tff_toggle_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping
// modulo NREQ; returns a one-hot grant and the binary winner index.
module rr_arbiter
  import tff_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);

  localparam int unsigned PW     = $clog2(NREQ);
  localparam logic [PW:0] NREQ_W = NREQ[PW:0];

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    // Wrap via one extra bit and a conditional subtract so non-power-of-2 NREQ works.
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_i} + (PW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req_i[idx[PW-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[PW-1:0];
      end
    end
    if (found) grant_o[winner_o] = 1'b1;
  end

endmodule

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler sharing one toggle-flop bank among NREQ requesters.
// Define TFF_SCHED_PARITY_EN to add the registered even-parity output q_par.
module tff_toggle_sched
  import tff_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
`ifdef TFF_SCHED_PARITY_EN
  ,
  output logic                  q_par
`endif
);

  localparam int unsigned PW   = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ-1);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  bank_q, bank_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [NREQ-1:0]   arb_grant;
  logic [PW-1:0]     arb_win;
  logic [WIDTH-1:0]  arb_mask;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .grant_o  (arb_grant),
    .winner_o (arb_win)
  );

  always_comb begin
    arb_mask = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) arb_mask = mask[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = arb_win;
          sel_d   = arb_grant;
          mask_d  = arb_mask;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        bank_d  = bank_q ^ mask_q;
        gnt_d   = sel_q;
        ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over a toggle, but grant and pointer still advance.
    if (clr) bank_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      bank_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      gnt_q   <= gnt_d;
    end
  end

  assign q    = bank_q;
  assign gnt  = gnt_q;
  assign busy = (state_q == ST_APPLY);

`ifdef TFF_SCHED_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= ^bank_d;
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Self-checking bench for tff_toggle_sched: directed scenarios plus randomized
// traffic against a transaction-level round-robin model.
module tb_tff_toggle_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  busy;
`ifdef TFF_SCHED_PARITY_EN
  logic                  q_par;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] m_q;
  int               m_ptr;

  tff_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .req   (req),
    .mask  (mask),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy)
`ifdef TFF_SCHED_PARITY_EN
    ,
    .q_par (q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_mask(input int i, input logic [WIDTH-1:0] v);
    mask[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    clr   = 1'b0;
    tick();
    reset = 1'b1;
    m_q   = '0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr   = 1'b0;
    req   = 4'b1111;
    mask  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (q !== '0)   begin n_err++; $display("FAIL reset_q: got %h expected 00", q); end
      n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    end
    reset = 1'b1;
    m_q = '0;
    m_ptr = 0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy: got %b expected 1", busy); end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    req = '0;
    m_ptr = 1;
    tick();
  endtask

  task automatic test_single_toggle();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      set_mask(1, 8'hA5);
      req = 4'b0010;
      tick();
      n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL single_gnt_early: got %b expected 0000", gnt); end
      tick();
      m_q = m_q ^ 8'hA5;
      n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b expected 0010", gnt); end
      n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL single_q: got %h expected %h", q, m_q); end
      req = '0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_mask(i, 8'h01);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = n % NREQ;
      tick();
      n_cmp++; if (busy !== 1'b1 || gnt !== '0) begin n_err++; $display("FAIL rr_apply_phase: got busy=%b gnt=%b expected busy=1 gnt=0000", busy, gnt); end
      tick();
      m_q = m_q ^ 8'h01;
      n_cmp++; if (gnt !== onehot(w)) begin n_err++; $display("FAIL rr_gnt%0d: got %b expected %b", n, gnt, onehot(w)); end
      n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL rr_q%0d: got %h expected %h", n, q, m_q); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_clr_collision();
    do_reset();
    set_mask(2, 8'hFF);
    req = 4'b0100;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL clr_q: got %h expected 00", q); end
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL clr_gnt: got %b expected 0100", gnt); end
    set_mask(0, 8'h0F);
    set_mask(3, 8'hF0);
    req = 4'b1001;
    tick();
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL clr_ptr_gnt: got %b expected 1000", gnt); end
    n_cmp++; if (q !== 8'hF0) begin n_err++; $display("FAIL clr_ptr_q: got %h expected f0", q); end
    req = '0;
    m_q = 8'hF0;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_reset_mid_apply();
    do_reset();
    set_mask(1, 8'h3C);
    req = 4'b0010;
    tick();
    tick();
    n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL rma_setup_q: got %h expected 3c", q); end
    set_mask(2, 8'hFF);
    req = 4'b0100;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rma_q: got %h expected 00", q); end
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL rma_gnt: got %b expected 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rma_busy: got %b expected 0", busy); end
    reset = 1'b1;
    set_mask(0, 8'h11);
    req = 4'b0101;
    tick();
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rma_next_gnt: got %b expected 0001", gnt); end
    n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL rma_next_q: got %h expected 11", q); end
    req = '0;
    m_q = 8'h11;
    m_ptr = 1;
    tick();
  endtask

`ifdef TFF_SCHED_PARITY_EN
  task automatic test_parity();
    do_reset();
    n_cmp++; if (q_par !== 1'b0) begin n_err++; $display("FAIL par_reset: got %b expected 0", q_par); end
    set_mask(0, 8'h07);
    req = 4'b0001;
    tick();
    tick();
    n_cmp++; if (q_par !== 1'b1) begin n_err++; $display("FAIL par_07: got %b expected 1", q_par); end
    set_mask(1, 8'h01);
    req = 4'b0010;
    tick();
    tick();
    n_cmp++; if (q !== 8'h06) begin n_err++; $display("FAIL par_q06: got %h expected 06", q); end
    n_cmp++; if (q_par !== 1'b0) begin n_err++; $display("FAIL par_06: got %b expected 0", q_par); end
    req = '0;
    m_q = 8'h06;
    m_ptr = 2;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [NREQ-1:0]  r;
      logic [WIDTH-1:0] exp_mask;
      logic             c_apply;
      int               w;
      r    = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      mask = $urandom;
      clr  = ($urandom_range(0, 7) == 0);
      req  = r;
      w    = rr_pick(r, m_ptr);
      exp_mask = (w >= 0) ? mask[w*WIDTH +: WIDTH] : '0;
      if (clr) m_q = '0;
      tick();
      clr = 1'b0;
      n_cmp++; if (busy !== (w >= 0)) begin n_err++; $display("FAIL rnd_busy%0d: got %b expected %b", n, busy, (w >= 0)); end
      n_cmp++; if (q !== m_q || gnt !== '0) begin n_err++; $display("FAIL rnd_arb%0d: got q=%h gnt=%b expected q=%h gnt=0000", n, q, gnt, m_q); end
      if (w >= 0) begin
        mask    = $urandom;
        req     = r & NREQ'($urandom_range(0, (1 << NREQ) - 1));
        c_apply = ($urandom_range(0, 4) == 0);
        clr     = c_apply;
        tick();
        clr   = 1'b0;
        m_q   = c_apply ? '0 : (m_q ^ exp_mask);
        m_ptr = (w + 1) % NREQ;
        n_cmp++; if (gnt !== onehot(w)) begin n_err++; $display("FAIL rnd_gnt%0d: got %b expected %b", n, gnt, onehot(w)); end
        n_cmp++; if (q !== m_q) begin n_err++; $display("FAIL rnd_q%0d: got %h expected %h", n, q, m_q); end
`ifdef TFF_SCHED_PARITY_EN
        n_cmp++; if (q_par !== ^m_q) begin n_err++; $display("FAIL rnd_par%0d: got %b expected %b", n, q_par, ^m_q); end
`endif
      end
    end
    req = '0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    clr   = 1'b0;
    req   = '0;
    mask  = '0;
    m_q   = '0;
    m_ptr = 0;
    test_reset();
    test_single_toggle();
    test_round_robin();
    test_clr_collision();
    test_reset_mid_apply();
`ifdef TFF_SCHED_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
